// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - Round-robin arbiter sharing one CORDIC accelerator among NUM_REQ requesters
module cordic_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_en,
    input  logic [NUM_REQ-1:0]     req_start,
    input  logic [32*NUM_REQ-1:0]  req_x_ft,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [31:0]            req_result,
    output logic                   req_err,
    output logic                   busy,
    output logic                   acc_start,
    output logic [31:0]            acc_x_ft,
    input  logic                   acc_done,
    input  logic [31:0]            acc_y_ft
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [31:0]        op_q [NUM_REQ];
    logic [31:0]        op_d [NUM_REQ];
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [31:0]        result_q, result_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [31:0]        acc_x_q, acc_x_d;

    logic [GW-1:0]      next_hi, next_lo, next_grant;
    logic               found_hi;
    logic               resp_now;

    // Lowest pending index above last_grant wins; otherwise wrap to lowest pending overall.
    always_comb begin
        next_hi  = '0;
        next_lo  = '0;
        found_hi = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                next_lo = GW'(i);
                if (i > int'(last_grant_q)) begin
                    next_hi  = GW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        next_grant = found_hi ? next_hi : next_lo;
    end

    assign resp_now = (state_q == S_RESP);

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        op_d         = op_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        acc_x_d      = acc_x_q;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d      = S_LAUNCH;
                    last_grant_d = next_grant;
                    acc_x_d      = op_q[next_grant];
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // The first WAIT cycle still shows the previous operation's done level.
                if (acc_done && (cnt_q != '0)) begin
                    state_d  = S_RESP;
                    result_d = acc_y_ft;
                    err_d    = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = S_RESP;
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            S_RESP: begin
                state_d                 = S_IDLE;
                pending_d[last_grant_q] = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // A start in the requester's own done cycle is a fresh request, not a duplicate.
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_start[r] && (!pending_q[r] || (resp_now && (last_grant_q == GW'(r))))) begin
                pending_d[r] = 1'b1;
                op_d[r]      = req_x_ft[32*r +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            result_q     <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            acc_x_q      <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                op_q[r] <= '0;
            end
        end else if (clk_en) begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            acc_x_q      <= acc_x_d;
            op_q         <= op_d;
        end
    end

    always_comb begin
        req_done   = '0;
        req_result = '0;
        req_err    = 1'b0;
        if (resp_now) begin
            req_done[last_grant_q] = 1'b1;
            req_result             = result_q;
            req_err                = err_q;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign acc_start = (state_q == S_LAUNCH);
    assign acc_x_ft  = acc_x_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb/tb_cordic_arbiter.sv - Self-checking bench for cordic_arbiter
module tb_cordic_arbiter;

    localparam int NR       = 3;
    localparam int TO       = 8;
    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;
    localparam int TARGET   = 60;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_en;
    logic [NR-1:0]     req_start;
    logic [32*NR-1:0]  req_x_ft;
    logic [NR-1:0]     req_done;
    logic [31:0]       req_result;
    logic              req_err;
    logic              busy;
    logic              acc_start;
    logic [31:0]       acc_x_ft;
    logic              acc_done;
    logic [31:0]       acc_y_ft;

    cordic_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .req_start  (req_start),
        .req_x_ft   (req_x_ft),
        .req_done   (req_done),
        .req_result (req_result),
        .req_err    (req_err),
        .busy       (busy),
        .acc_start  (acc_start),
        .acc_x_ft   (acc_x_ft),
        .acc_done   (acc_done),
        .acc_y_ft   (acc_y_ft)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          acc_rem, acc_delay, acc_mode;
    logic [31:0] acc_x_lat;

    typedef struct {
        int          r;
        logic [31:0] op;
        int          delay;
        int          mode;
        int          lat;
        logic        err;
        logic [31:0] res;
    } vec_t;

    vec_t          vecs [8];
    int            lat, launches;
    logic [31:0]   lx, res;
    logic [NR-1:0] dv, oh;
    logic          err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] acc_fn(input logic [31:0] x);
        if (x == 32'h3F80_0000) return 32'h3F0A_5140;
        return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Accelerator: done is a level that stays at its old value until a new operation is
    // well under way; called once per enabled cycle, at the negedge.
    task automatic acc_model();
        if (acc_start) begin
            acc_rem   = acc_delay;
            acc_x_lat = acc_x_ft;
            if (acc_mode == M_STUCK) begin
                acc_done = 1'b1;
                acc_y_ft = acc_fn(acc_x_ft);
            end
        end else if (acc_mode == M_STUCK) begin
            acc_done = 1'b1;
            acc_y_ft = acc_fn(acc_x_lat);
        end else if (acc_rem > 0) begin
            acc_rem--;
            if (acc_mode == M_NEVER || acc_rem != 0) begin
                acc_done = 1'b0;
            end else begin
                acc_done = 1'b1;
                acc_y_ft = acc_fn(acc_x_lat);
            end
        end
    endtask

    task automatic tick(input logic en, input logic [NR-1:0] st);
        @(negedge clk);
        clk_en    = en;
        req_start = st;
        if (en) acc_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        clk_en    = 1'b0;
        req_start = '0;
        acc_done  = 1'b0;
        acc_rem   = 0;
        acc_mode  = M_NORMAL;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_op(input int r, input logic [31:0] op, input int delay, input int mode,
                          output int o_lat, output int o_launches, output logic [31:0] o_lx,
                          output logic [NR-1:0] o_dv, output logic [31:0] o_res, output logic o_err);
        logic [NR-1:0] one;
        one = '0;
        one[r] = 1'b1;
        req_x_ft[32*r +: 32] = op;
        acc_delay  = delay;
        acc_mode   = mode;
        o_lat      = 0;
        o_launches = 0;
        o_lx       = '0;
        o_dv       = '0;
        o_res      = '0;
        o_err      = 1'b0;
        tick(1'b1, one);
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, '0);
            o_lat++;
            if (acc_start) begin
                o_launches++;
                o_lx = acc_x_ft;
            end
            if (req_done != '0) begin
                o_dv  = req_done;
                o_res = req_result;
                o_err = req_err;
                break;
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0]   lxs [4];
        logic [NR-1:0] dvs [4];
        logic [31:0]   drs [4];
        int nl, nd;
        nl = 0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            lxs[i] = '0; dvs[i] = '0; drs[i] = '0;
        end
        req_x_ft[31:0]  = 32'h3F80_0000;
        req_x_ft[63:32] = 32'h4000_0000;
        acc_mode  = M_NORMAL;
        acc_delay = 3;
        tick(1'b1, 3'b011);
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, '0);
            if (acc_start) begin
                if (nl < 4) lxs[nl] = acc_x_ft;
                nl++;
            end
            if (req_done != '0) begin
                if (nd < 4) begin
                    dvs[nd] = req_done;
                    drs[nd] = req_result;
                end
                nd++;
            end
        end
        check("sim_launches", nl, 2);
        check("sim_dones", nd, 2);
        check("sim_launch0_x", lxs[0], 32'h3F80_0000);
        check("sim_launch1_x", lxs[1], 32'h4000_0000);
        check("sim_done0_vec", dvs[0], 3'b001);
        check("sim_done0_res", drs[0], 32'h3F0A_5140);
        check("sim_done1_vec", dvs[1], 3'b010);
        check("sim_done1_res", drs[1], acc_fn(32'h4000_0000));
    endtask

    task automatic test_stall();
        logic          s_busy, s_start, frozen;
        logic [31:0]   s_x;
        logic [NR-1:0] s_done;
        int            l, stray;
        req_x_ft[95:64] = 32'hC0A0_0000;
        acc_mode  = M_NORMAL;
        acc_delay = 5;
        tick(1'b1, 3'b100);
        repeat (4) tick(1'b1, '0);
        l = 4;
        s_busy = busy; s_start = acc_start; s_x = acc_x_ft; s_done = req_done;
        check("stall_in_wait", s_busy, 1'b1);
        check("stall_hold_x", s_x, 32'hC0A0_0000);
        frozen = 1'b1;
        repeat (10) begin
            tick(1'b0, 3'b011);
            if (busy !== s_busy || acc_start !== s_start || acc_x_ft !== s_x || req_done !== s_done)
                frozen = 1'b0;
        end
        check("stall_frozen", frozen, 1'b1);
        dv = '0; res = '0; err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, '0);
            l++;
            if (req_done != '0) begin
                dv = req_done; res = req_result; err = req_err;
                break;
            end
        end
        check("stall_latency", l, 8);
        check("stall_done_vec", dv, 3'b100);
        check("stall_result", res, acc_fn(32'hC0A0_0000));
        check("stall_err", err, 1'b0);
        stray = 0;
        repeat (12) begin
            tick(1'b1, '0);
            if (acc_start || busy) stray++;
        end
        check("stall_starts_dropped", stray, 0);
    endtask

    task automatic test_midop_reset();
        int stray;
        req_x_ft[31:0] = 32'h3FC0_0000;
        acc_mode  = M_NEVER;
        acc_delay = 1;
        tick(1'b1, 3'b001);
        repeat (4) tick(1'b1, '0);
        check("mrst_busy_before", busy, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_busy_in_reset", busy, 1'b0);
        check("mrst_done_in_reset", req_done, 3'b000);
        check("mrst_x_in_reset", acc_x_ft, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        acc_mode = M_STUCK;
        acc_done = 1'b1;
        stray = 0;
        repeat (6) begin
            tick(1'b1, '0);
            if (req_done != '0 || busy) stray++;
        end
        check("mrst_late_done_ignored", stray, 0);
        run_op(1, 32'h40A0_0000, 4, M_NORMAL, lat, launches, lx, dv, res, err);
        check("mrst_r1_latency", lat, 7);
        check("mrst_r1_launches", launches, 1);
        check("mrst_r1_x", lx, 32'h40A0_0000);
        check("mrst_r1_done_vec", dv, 3'b010);
        check("mrst_r1_result", res, acc_fn(32'h40A0_0000));
        check("mrst_r1_err", err, 1'b0);
    endtask

    // Reference: an op requested in enabled cycle c is eligible for the grant made for a launch
    // at cycle c+2 or later; among eligible requests, the first after the last served wins.
    task automatic random_phase();
        logic [NR-1:0]    outst, launched, st, one;
        logic [31:0]      opm [NR];
        logic             experr [NR];
        int               iss [NR];
        int               last_m, cyc, issued, served, eg, c;
        logic             en, quiet;
        logic [32*NR-1:0] x;
        outst = '0; launched = '0; last_m = NR - 1;
        cyc = 0; issued = 0; served = 0; quiet = 1'b1;
        for (int r = 0; r < NR; r++) begin
            opm[r] = '0; experr[r] = 1'b0; iss[r] = 0;
        end
        for (int t = 0; t < 20000 && served < TARGET; t++) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) < 8);
            for (int r = 0; r < NR; r++) x[32*r +: 32] = $urandom();
            st = '0;
            if (en) begin
                if (req_done != '0) begin
                    one = '0;
                    one[last_m] = 1'b1;
                    check("rnd_done_inflight", launched[last_m], 1'b1);
                    check("rnd_done_vec", req_done, one);
                    check("rnd_result", req_result, experr[last_m] ? 32'h0 : acc_fn(opm[last_m]));
                    check("rnd_err", req_err, experr[last_m]);
                    outst[last_m] = 1'b0;
                    launched[last_m] = 1'b0;
                    served++;
                end else if (req_result != '0 || req_err) begin
                    quiet = 1'b0;
                end
                if (acc_start) begin
                    eg = -1;
                    for (int k = 1; k <= NR; k++) begin
                        c = (last_m + k) % NR;
                        if (eg < 0 && outst[c] && !launched[c] && iss[c] <= cyc - 2) eg = c;
                    end
                    if (eg < 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rnd_grant: launch at cycle %0d x=%h with no eligible request", cyc, acc_x_ft);
                    end else begin
                        check("rnd_launch_x", acc_x_ft, opm[eg]);
                        launched[eg] = 1'b1;
                        last_m = eg;
                        if ($urandom_range(0, 9) == 0) begin
                            experr[eg] = 1'b1; acc_mode = M_NEVER; acc_delay = 1;
                        end else begin
                            experr[eg] = 1'b0; acc_mode = M_NORMAL; acc_delay = $urandom_range(1, 7);
                        end
                    end
                end
                for (int r = 0; r < NR; r++) begin
                    if (!outst[r]) begin
                        if (issued < TARGET && $urandom_range(0, 9) < 3) begin
                            st[r] = 1'b1; opm[r] = x[32*r +: 32]; outst[r] = 1'b1;
                            iss[r] = cyc; issued++;
                        end
                    end else if ($urandom_range(0, 9) < 2) begin
                        st[r] = 1'b1;
                    end
                end
                cyc++;
            end else begin
                st = NR'($urandom());
            end
            clk_en    = en;
            req_start = st;
            req_x_ft  = x;
            if (en) acc_model();
        end
        check("rnd_served", served, TARGET);
        check("rnd_quiet_outside_resp", quiet, 1'b1);
    endtask

    initial begin
        vecs[0] = '{0, 32'h3F80_0000, 5, M_NORMAL,  8, 1'b0, 32'h3F0A_5140};
        vecs[1] = '{1, 32'h4049_0FDB, 1, M_NORMAL,  5, 1'b0, acc_fn(32'h4049_0FDB)};
        vecs[2] = '{2, 32'hBF00_0000, 3, M_NORMAL,  6, 1'b0, acc_fn(32'hBF00_0000)};
        vecs[3] = '{0, 32'h3F00_0000, 1, M_NEVER,  11, 1'b1, 32'h0};
        vecs[4] = '{1, 32'h3E80_0000, 1, M_STUCK,   5, 1'b0, acc_fn(32'h3E80_0000)};
        vecs[5] = '{2, 32'h4120_0000, 7, M_NORMAL, 10, 1'b0, acc_fn(32'h4120_0000)};
        vecs[6] = '{0, 32'h3DCC_CCCD, 8, M_NORMAL, 11, 1'b0, acc_fn(32'h3DCC_CCCD)};
        vecs[7] = '{1, 32'h4248_0000, 9, M_NORMAL, 11, 1'b1, 32'h0};

        reset = 1'b1; clk_en = 1'b0; req_start = '0; req_x_ft = '0;
        acc_done = 1'b0; acc_y_ft = '0; acc_rem = 0; acc_delay = 1;
        acc_mode = M_NORMAL; acc_x_lat = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_acc_start", acc_start, 1'b0);
        check("rst_req_done", req_done, 3'b000);
        check("rst_req_err", req_err, 1'b0);
        check("rst_req_result", req_result, 32'h0);
        check("rst_acc_x", acc_x_ft, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        test_simultaneous();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].r, vecs[i].op, vecs[i].delay, vecs[i].mode, lat, launches, lx, dv, res, err);
            oh = '0;
            oh[vecs[i].r] = 1'b1;
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_launches", i), launches, 1);
            check($sformatf("v%0d_acc_x", i), lx, vecs[i].op);
            check($sformatf("v%0d_done_vec", i), dv, oh);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_err", i), err, vecs[i].err);
            tick(1'b1, '0);
            check($sformatf("v%0d_back_to_idle", i), busy, 1'b0);
        end

        test_stall();
        test_midop_reset();
        do_reset();
        random_phase();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one CORDIC accelerator (legal range 2..8).
REQ-002 Parameter TIMEOUT, default 64, maximum clk_en cycles to wait for accelerator done before aborting.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 clk_en  in  1  clock enable; when low, all state and outputs hold.
REQ-006 req_start  in  NUM_REQ  per-requester start pulse, one bit per requester.
REQ-007 req_x_ft  in  32*NUM_REQ  per-requester IEEE-754 single operand; requester r occupies bits [32r+31:32r].
REQ-008 req_done  out  NUM_REQ  per-requester completion pulse, one bit per requester.
REQ-009 req_result  out  32  shared result float, valid only while any req_done bit is high.
REQ-010 req_err  out  1  timeout flag, valid only while any req_done bit is high.
REQ-011 busy  out  1  high while the FSM is not in IDLE.
REQ-012 acc_start  out  1  start pulse to the accelerator.
REQ-013 acc_x_ft  out  32  operand to the accelerator, held stable from the acc_start cycle until the operation ends.
REQ-014 acc_done  in  1  accelerator done level.
REQ-015 acc_y_ft  in  32  accelerator float result.

Function
REQ-016 Cycle definition: every cycle count and pulse width below is in clk_en-qualified cycles; when clk_en is low, nothing advances.
REQ-017 Request capture:
  - req_start[r] sampled high with pending[r]=0 sets pending[r] and latches req_x_ft slice r into op_reg[r].
  - req_start[r] sampled while pending[r]=1 is ignored; op_reg[r] is unchanged.
REQ-018 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-019 IDLE -> LAUNCH when any pending bit is set.
  - Grant goes to the first pending index strictly after last_grant, searching upward with wrap-around.
  - last_grant is updated to the granted index.
REQ-020 In LAUNCH, acc_start=1 and acc_x_ft=op_reg[grant] for exactly one cycle; the next state is WAIT.
REQ-021 acc_done masking:
  - In WAIT, acc_done is ignored during the first cycle, because the accelerator's done level is stale from the previous operation.
  - From the second WAIT cycle on, acc_done=1 moves the FSM to RESP and captures acc_y_ft into the result register with err=0.
REQ-022 Timeout:
  - A wait counter is cleared on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT without a qualified acc_done, the FSM goes to RESP with result=0 and err=1.
REQ-023 In RESP, req_done[grant]=1 for exactly one cycle with req_result and req_err driven; pending[grant] clears; the next state is IDLE.
REQ-024 Outside RESP, req_done=0, req_result=0 and req_err=0.
REQ-025 Latency, idle arbiter, start sampled at cycle N:
  - pending set at N+1, LAUNCH at N+2, WAIT from N+3.
  - With acc_done first qualified at cycle M, req_done is high at M+1.
REQ-026 Restart in the done cycle: if req_start[r] is sampled in the same cycle that req_done[r] is high, the new request is accepted; pending[r] remains 1 and op_reg[r] is reloaded.
REQ-027 Fairness: with all requesters continuously pending, grants rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 operations.
REQ-028 acc_x_ft holds its value when not in LAUNCH or WAIT.
REQ-029 req_start edges arriving while clk_en is low are not captured.

Reset
REQ-030 Reset forces the following, regardless of clk_en:
  - FSM to IDLE.
  - pending, op_reg, result register, wait counter and acc_x_ft to 0.
  - last_grant to NUM_REQ-1, so the first grant goes to requester 0.
REQ-031 During and after reset, acc_start, req_done, req_err and busy are 0.
REQ-032 Reset mid-operation abandons the operation silently: no req_done is issued, and a late acc_done arriving in IDLE is ignored.

Verification
REQ-033 Single request: req_start[0] with x=0x3F800000, accelerator model returns 0x3F0A5140 after 5 cycles -> acc_start high once with acc_x_ft=0x3F800000; req_done[0] pulses once with result 0x3F0A5140 and err=0.
REQ-034 Simultaneous request: req_start=2'b11 in one cycle -> requester 0 served first, then requester 1; each receives exactly one req_done carrying its own operand's result.
REQ-035 Timeout: TIMEOUT=8 with acc_done held low -> req_done[0] pulses exactly 8 WAIT cycles after entry with result 0 and err=1; FSM returns to IDLE.
REQ-036 Stale done: acc_done held high across LAUNCH and the first WAIT cycle -> acc_done is not accepted before the second WAIT cycle.
REQ-037 Stall: clk_en low for 10 cycles during WAIT -> counter, outputs and state frozen; the operation completes normally after clk_en returns.
REQ-038 Mid-operation reset: reset asserted in WAIT -> no req_done is issued; after release, a new req_start[1] is granted to requester 1 and completes normally.
